// File: rtl/bubsys_framegrab_ctrl.sv
// Frame-grab controller: captures one 256x224 active frame into a capture RAM via a small pixel FIFO.
// Optional macro BUBSYS_FRAMEGRAB_BOTTOMUP_EN stores lines bottom-up (line index 223-y).
module bubsys_framegrab_ctrl #(
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter int          FIFO_DEPTH_LOG2 = 3
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_MRST_n,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [8:0]  i_HCOUNTER,
  input  logic [8:0]  i_VCOUNTER,
  input  logic [15:0] i_VIDEODATA,
  input  logic        i_ARM,
  input  logic        i_CONTINUOUS,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_OVERRUN,
  output logic [7:0]  o_FRAME_CNT,
  output logic        o_MEM_REQ,
  input  logic        i_MEM_ACK,
  output logic [15:0] o_MEM_ADDR,
  output logic [14:0] o_MEM_DATA
);

  // state   | meaning
  // IDLE    | waiting for i_ARM
  // ARMED   | waiting for frame start (V=272, H=277)
  // CAPTURE | pushing active-window pixels into the FIFO
  // DRAIN   | last pixel pushed, waiting for the FIFO to empty

  localparam int                       L_DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] L_FULL   = (FIFO_DEPTH_LOG2+1)'(L_DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] L_CNT_1  = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] L_PTR_1 = (FIFO_DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_pix_en;
  logic        w_in_v;
  logic        w_in_h;
  logic        w_frame_start;
  logic        w_frame_last;
  logic [7:0]  w_x;
  logic [7:0]  w_y;
  logic [7:0]  w_line;
  logic [15:0] w_addr;
  logic        w_unused_vid15;

  logic [30:0]                r_mem [L_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_overrun;
  logic [7:0]                 r_frame_cnt;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_drop;
  logic        w_arm_evt;
  logic        w_done_evt;
  logic [30:0] w_head;

  assign w_pix_en       = ~i_EMU_CLK6MPCEN_n;
  assign w_unused_vid15 = i_VIDEODATA[15];

  assign w_in_v = (i_VCOUNTER >= 9'd272) && (i_VCOUNTER <= 9'd495);
  assign w_in_h = (i_HCOUNTER >= 9'd278) ||
                  ((i_HCOUNTER >= 9'd128) && (i_HCOUNTER <= 9'd149));

  assign w_frame_start = w_pix_en && (i_VCOUNTER == 9'd272) && (i_HCOUNTER == 9'd277);
  assign w_frame_last  = w_pix_en && (i_VCOUNTER == 9'd495) && (i_HCOUNTER == 9'd149);

  // Modulo-256 arithmetic on the low counter bits: 278-256=22, 234-128=106, 272-256=16.
  assign w_x = (i_HCOUNTER >= 9'd278) ? (i_HCOUNTER[7:0] - 8'd22)
                                      : (i_HCOUNTER[7:0] + 8'd106);
  assign w_y = i_VCOUNTER[7:0] - 8'd16;

`ifdef BUBSYS_FRAMEGRAB_BOTTOMUP_EN
  assign w_line = 8'd223 - w_y;
`else
  assign w_line = w_y;
`endif

  assign w_addr = BASE_ADDR + {w_line, w_x};

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_FULL);
  assign w_pop   = ~w_empty & i_MEM_ACK;
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_MRST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (i_ARM) w_state_nxt = S_ARMED;
      S_ARMED:   if (w_frame_start) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_frame_last) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_empty) w_state_nxt = i_CONTINUOUS ? S_ARMED : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_BUSY     = 1'b1;
    w_push_req = 1'b0;
    w_arm_evt  = 1'b0;
    w_done_evt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_BUSY    = 1'b0;
        w_arm_evt = i_ARM;
      end
      S_CAPTURE: w_push_req = w_pix_en & w_in_v & w_in_h;
      S_DRAIN:   w_done_evt = w_empty;
      default:   ;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_MRST_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_1;
      if (w_push && !w_pop) begin
        r_count <= r_count + L_CNT_1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - L_CNT_1;
      end
      if (w_arm_evt) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_done_evt) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Entries carry their own address, so dropped pixels never shift later ones.
  always_ff @(posedge i_EMU_MCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_addr, i_VIDEODATA[14:0]};
  end

  assign o_DONE      = w_done_evt;
  assign o_OVERRUN   = r_overrun;
  assign o_FRAME_CNT = r_frame_cnt;
  assign o_MEM_REQ   = ~w_empty;
  assign o_MEM_ADDR  = w_empty ? 16'h0000 : w_head[30:15];
  assign o_MEM_DATA  = w_empty ? 15'h0000 : w_head[14:0];

endmodule

// File: tb/tb_bubsys_framegrab_ctrl.sv
// Self-checking bench for bubsys_framegrab_ctrl: table-driven pixel mapping plus multi-cycle sequences.
// Honours BUBSYS_FRAMEGRAB_BOTTOMUP_EN for expected addresses.
module tb_bubsys_framegrab_ctrl;

  localparam logic [15:0] TB_BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcen_n;
  logic [8:0]  hc;
  logic [8:0]  vc;
  logic [15:0] vid;
  logic        arm;
  logic        cont;
  logic        ack;
  logic        busy;
  logic        done;
  logic        ovr;
  logic [7:0]  fcnt;
  logic        req;
  logic [15:0] maddr;
  logic [14:0] mdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bubsys_framegrab_ctrl dut (
    .i_EMU_MCLK(clk),
    .i_EMU_MRST_n(rst_n),
    .i_EMU_CLK6MPCEN_n(pcen_n),
    .i_HCOUNTER(hc),
    .i_VCOUNTER(vc),
    .i_VIDEODATA(vid),
    .i_ARM(arm),
    .i_CONTINUOUS(cont),
    .o_BUSY(busy),
    .o_DONE(done),
    .o_OVERRUN(ovr),
    .o_FRAME_CNT(fcnt),
    .o_MEM_REQ(req),
    .i_MEM_ACK(ack),
    .o_MEM_ADDR(maddr),
    .o_MEM_DATA(mdata)
  );

  function automatic logic [15:0] exp_addr(input int y, input int x);
    int yy;
`ifdef BUBSYS_FRAMEGRAB_BOTTOMUP_EN
    yy = 223 - y;
`else
    yy = y;
`endif
    return TB_BASE + 16'(yy * 256 + x);
  endfunction

  function automatic logic [14:0] exp_vid(input int y, input int x);
    logic [7:0] yb;
    logic [7:0] xb;
    yb = 8'(y);
    xb = 8'(x);
    return {yb[4:0], xb[4:0], 5'h00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; cont = 1'b0; ack = 1'b0;
    pcen_n = 1'b1; hc = 9'd0; vc = 9'd0; vid = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pix(input int v, input int h, input logic [15:0] d);
    vc = v[8:0];
    hc = h[8:0];
    vid = d;
    pcen_n = 1'b0;
    tick();
    pcen_n = 1'b1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Write monitor, sampled on the falling edge; a write is REQ&&ACK before the next rising edge.
  logic        mon_clr = 1'b0;
  logic        mon_frame_chk = 1'b0;
  logic        mon_busy_chk = 1'b0;
  int          mon_writes = 0;
  int          mon_bad = 0;
  int          mon_done = 0;
  int          mon_busy_drop = 0;
  logic [15:0] mon_last = 16'h0000;
  logic [15:0] wq[$];

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_writes    <= 0;
      mon_bad       <= 0;
      mon_done      <= 0;
      mon_busy_drop <= 0;
      mon_last      <= 16'h0000;
      wq.delete();
    end else begin
      if (req && ack) begin
        wq.push_back(maddr);
        mon_last   <= maddr;
        mon_writes <= mon_writes + 1;
        if (mon_frame_chk &&
            ((maddr !== exp_addr(mon_writes / 256, mon_writes % 256)) ||
             (mdata !== exp_vid(mon_writes / 256, mon_writes % 256))))
          mon_bad <= mon_bad + 1;
      end
      if (done) mon_done <= mon_done + 1;
      if (mon_busy_chk && !busy) mon_busy_drop <= mon_busy_drop + 1;
    end
  end

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic frame_pix(input int v, input int h);
    int  x;
    int  y;
    logic win;
    y = v - 272;
    x = (h >= 278) ? h - 278 : h - 128 + 234;
    win = (v >= 272) && (v <= 495) && ((h >= 278) || ((h >= 128) && (h <= 149)));
    vc = v[8:0];
    hc = h[8:0];
    vid = win ? {1'b0, exp_vid(y, x)} : 16'hFFFF;
    pcen_n = 1'b0;
    tick();
  endtask

  task automatic run_line(input int v);
    for (int h = 277; h <= 511; h++) frame_pix(v, h);
    for (int h = 128; h <= 150; h++) frame_pix(v, h);
  endtask

  typedef struct {
    logic [8:0]  v;
    logic [8:0]  h;
    logic        en;
    logic [15:0] d;
    logic        exp_req;
    int          ey;
    int          ex;
    logic [14:0] exp_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{9'd272, 9'd278, 1'b1, 16'h0001, 1'b1, 0,   0,   15'h0001};
    vt[1]  = '{9'd280, 9'd130, 1'b1, 16'h8ABC, 1'b1, 8,   236, 15'h0ABC};
    vt[2]  = '{9'd272, 9'd511, 1'b1, 16'h7FFF, 1'b1, 0,   233, 15'h7FFF};
    vt[3]  = '{9'd272, 9'd128, 1'b1, 16'h1111, 1'b1, 0,   234, 15'h1111};
    vt[4]  = '{9'd300, 9'd400, 1'b1, 16'h2468, 1'b1, 28,  122, 15'h2468};
    vt[5]  = '{9'd495, 9'd149, 1'b1, 16'hD555, 1'b1, 223, 255, 15'h5555};
    vt[6]  = '{9'd271, 9'd300, 1'b1, 16'h1234, 1'b0, 0,   0,   15'h0000};
    vt[7]  = '{9'd300, 9'd150, 1'b1, 16'h1234, 1'b0, 0,   0,   15'h0000};
    vt[8]  = '{9'd300, 9'd277, 1'b1, 16'h1234, 1'b0, 0,   0,   15'h0000};
    vt[9]  = '{9'd496, 9'd300, 1'b1, 16'h1234, 1'b0, 0,   0,   15'h0000};
    vt[10] = '{9'd300, 9'd300, 1'b0, 16'h1234, 1'b0, 0,   0,   15'h0000};
    vt[11] = '{9'd272, 9'd127, 1'b1, 16'h1234, 1'b0, 0,   0,   15'h0000};

    // Reset state
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_addr", maddr, 16'h0000);
    chk("rst_data", mdata, 15'h0000);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", ovr, 1'b0);
    chk("rst_frame_cnt", fcnt, 8'd0);

    // Arm mid-frame: no writes until the next frame start
    ack = 1'b1;
    vc = 9'd300; hc = 9'd300;
    arm_pulse();
    chk("midarm_busy", busy, 1'b1);
    pix(300, 300, 16'h0AAA);
    pix(300, 400, 16'h0BBB);
    chk("midarm_no_req", req, 1'b0);
    pix(272, 277, 16'h0CCC);
    chk("midarm_start_no_req", req, 1'b0);
    pix(272, 278, 16'h9234);
    chk("midarm_first_req", req, 1'b1);
    chk("midarm_first_addr", maddr, exp_addr(0, 0));
    chk("midarm_first_data", mdata, 15'h1234);
    tick();
    chk("midarm_popped", req, 1'b0);

    // Table-driven single-pixel mapping
    for (int i = 0; i < NV; i++) begin
      do_reset();
      arm_pulse();
      pix(272, 277, 16'h0000);
      vc = vt[i].v;
      hc = vt[i].h;
      vid = vt[i].d;
      pcen_n = ~vt[i].en;
      tick();
      pcen_n = 1'b1;
      chk($sformatf("vec%0d_req", i), req, vt[i].exp_req);
      chk($sformatf("vec%0d_addr", i), maddr,
          vt[i].exp_req ? exp_addr(vt[i].ey, vt[i].ex) : 16'h0000);
      chk($sformatf("vec%0d_data", i), mdata, vt[i].exp_data);
    end

    // Full frame with ACK tied high
    do_reset();
    clr_mon();
    ack = 1'b1;
    mon_frame_chk = 1'b1;
    arm_pulse();
    for (int v = 271; v <= 496; v++) run_line(v);
    pcen_n = 1'b1;
    for (int i = 0; i < 50 && busy; i++) tick();
    mon_frame_chk = 1'b0;
    chk("frame_writes", mon_writes, 57344);
    chk("frame_content_bad", mon_bad, 0);
    chk("frame_last_addr", mon_last, exp_addr(223, 255));
    chk("frame_done_pulses", mon_done, 1);
    chk("frame_cnt", fcnt, 8'd1);
    chk("frame_overrun", ovr, 1'b0);
    chk("frame_idle", busy, 1'b0);

    // Memory stall during line 0 -> overrun, no address slip
    do_reset();
    clr_mon();
    arm_pulse();
    pix(272, 277, 16'h0000);
    ack = 1'b0;
    for (int i = 0; i < 40; i++) pix(272, 278 + i, {1'b0, exp_vid(0, i)});
    chk("stall_overrun", ovr, 1'b1);
    chk("stall_req_held", req, 1'b1);
    chk("stall_head_addr", maddr, exp_addr(0, 0));
    ack = 1'b1;
    for (int i = 40; i < 50; i++) pix(272, 278 + i, {1'b0, exp_vid(0, i)});
    repeat (12) tick();
    chk("stall_write_count", wq.size(), 18);
    if (wq.size() == 18) begin
      for (int i = 0; i < 8; i++) chk($sformatf("stall_wr%0d", i), wq[i], exp_addr(0, i));
      chk("stall_wr8", wq[8], exp_addr(0, 40));
      chk("stall_wr17", wq[17], exp_addr(0, 49));
    end
    pix(495, 149, 16'h0000);
    repeat (5) tick();
    chk("stall_end_idle", busy, 1'b0);
    chk("stall_ovr_sticky", ovr, 1'b1);
    chk("stall_frame_cnt", fcnt, 8'd1);
    arm_pulse();
    chk("rearm_ovr_clear", ovr, 1'b0);
    chk("rearm_busy", busy, 1'b1);

    // Continuous mode over three (sparse) frames
    do_reset();
    clr_mon();
    cont = 1'b1;
    ack = 1'b1;
    arm_pulse();
    mon_busy_chk = 1'b1;
    for (int f = 0; f < 3; f++) begin
      pix(272, 277, 16'h0000);
      pix(272, 278, 16'h0123);
      pix(495, 149, 16'h0456);
      repeat (4) tick();
    end
    mon_busy_chk = 1'b0;
    chk("cont_done_pulses", mon_done, 3);
    chk("cont_frame_cnt", fcnt, 8'd3);
    chk("cont_busy_drop", mon_busy_drop, 0);
    chk("cont_still_armed", busy, 1'b1);
    chk("cont_writes", mon_writes, 6);
    cont = 1'b0;

    // Reset while draining with five entries queued
    do_reset();
    clr_mon();
    arm_pulse();
    pix(272, 277, 16'h0000);
    for (int i = 0; i < 4; i++) pix(272, 278 + i, 16'h0011);
    pix(495, 149, 16'h0022);
    chk("drain_busy", busy, 1'b1);
    chk("drain_req", req, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("drainrst_req", req, 1'b0);
    chk("drainrst_busy", busy, 1'b0);
    ack = 1'b1;
    repeat (10) tick();
    chk("drainrst_done", mon_done, 0);
    chk("drainrst_frame_cnt", fcnt, 8'd0);
    chk("drainrst_writes", mon_writes, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
